bus_target: RTL

Word-addressed memory responder on the far side of the CPU's `rdata`/`wdata`/`addr`/`re`/`we` bus. It serves on-chip RAM and a small MMIO page holding:
- a transmit byte FIFO with a valid/ready output stream;
- a status register;
- a 64-bit free-running cycle counter with atomic hi/lo read.

It sits at the top level between `cpu` and the board I/O, and is the only responder on the bus.

---
 rtl/bus_target.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bus_target.sv
// Word-addressed bus responder: RAM plus an MMIO page (TX byte FIFO, STATUS, 64-bit cycle counter).
// Reads have 1-cycle latency. tx_valid/tx_ready never stalls the bus; a push into a full FIFO with no pop is dropped and sets OVF.
module bus_target #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int RAM_DEPTH  = 1 << RAM_AW;
  localparam logic [3:0] REG_TXDATA = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_CNT_LO = 4'd2;
  localparam logic [3:0] REG_CNT_HI = 4'd3;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  logic              sel_mmio;
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0]        reg_idx;
  logic              ram_rd, ram_wr, mmio_rd, mmio_wr;
  logic              unused_addr;

  assign sel_mmio    = addr[29];
  assign ram_idx     = addr[RAM_AW-1:0];
  assign reg_idx     = addr[3:0];
  assign ram_rd      = re & ~sel_mmio;
  assign ram_wr      = we & ~sel_mmio;
  assign mmio_rd     = re & sel_mmio;
  assign mmio_wr     = we & sel_mmio;
  assign unused_addr = ^addr[28:RAM_AW];

  // RAM: no reset so it maps onto block RAM; read-before-write on the same port.
  logic [31:0] ram [0:RAM_DEPTH-1];
  logic [31:0] ram_q;

  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_idx] <= wdata;
    if (ram_rd) ram_q <= ram[ram_idx];
  end

  logic [7:0]       fifo_mem [0:FIFO_DEPTH-1];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic             pop, push_req, push, drop, status_clr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;

  // A concurrent pop frees the slot, so a push into a full FIFO still lands.
  assign pop        = tx_valid & tx_ready;
  assign push_req   = mmio_wr & (reg_idx == REG_TXDATA);
  assign push       = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;
  assign status_clr = mmio_wr & (reg_idx == REG_STATUS) & wdata[2];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= wdata[7:0];
  end

  assign tx_valid = ~fifo_empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr[FIFO_AW-1:0]] : 8'h00;

  logic        ovf;
  logic [63:0] counter;
  logic [31:0] shadow_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf       <= 1'b0;
      counter   <= '0;
      shadow_hi <= '0;
    end else begin
      counter <= counter + 64'd1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)            ovf <= 1'b1;
      else if (status_clr) ovf <= 1'b0;
      if (mmio_rd && reg_idx == REG_CNT_LO) shadow_hi <= counter[63:32];
    end
  end

  logic [31:0] status_word;
  logic [31:0] mmio_rdata;

  always_comb begin
    status_word                  = '0;
    status_word[0]               = fifo_empty;
    status_word[1]               = fifo_full;
    status_word[2]               = ovf;
    status_word[8 +: FIFO_AW+1]  = fifo_count;
  end

  always_comb begin
    mmio_rdata = '0;
    case (reg_idx)
      REG_STATUS: mmio_rdata = status_word;
      REG_CNT_LO: mmio_rdata = counter[31:0];
      REG_CNT_HI: mmio_rdata = shadow_hi;
      default:    mmio_rdata = '0;
    endcase
  end

  // rdata is a registered mux: the RAM half holds in ram_q, the MMIO half in mmio_q.
  logic        rd_from_ram;
  logic [31:0] mmio_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_from_ram <= 1'b0;
      mmio_q      <= '0;
    end else if (re) begin
      rd_from_ram <= ~sel_mmio;
      if (sel_mmio) mmio_q <= mmio_rdata;
    end
  end

  assign rdata = rd_from_ram ? ram_q : mmio_q;

endmodule
